round_robin_arbiter_n: RTL and testbench

ROUND_ROBIN_ARBITER_N -- requirements
Module: round_robin_arbiter_n

---
 rtl/round_robin_arbiter_n.sv | 99 +++++++++
 tb/tb_round_robin_arbiter_n.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/round_robin_arbiter_n.sv
// N-way round-robin arbiter with combinational grant and rotating priority pointer.
// Optional grant-lock tenure mode enabled by defining ROUND_ROBIN_ARBITER_N_LOCK_EN.
module round_robin_arbiter_n #(
    parameter int unsigned N        = 4,
    parameter int unsigned MAX_HOLD = 4,
    parameter int unsigned IDX_W    = $clog2(N)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N-1:0]     requests,
    output logic [N-1:0]     grants,
    output logic             grant_valid,
    output logic [IDX_W-1:0] grant_idx,
    output logic             locked
);

    // Elaboration-time parameter range checks.
    if (N < 2 || N > 16) begin : g_bad_n
        $error("round_robin_arbiter_n: N out of range");
    end
    if (MAX_HOLD < 1 || MAX_HOLD > 255) begin : g_bad_hold
        $error("round_robin_arbiter_n: MAX_HOLD out of range");
    end

    logic [IDX_W-1:0] ptr;
    logic [IDX_W-1:0] norm_idx;
    logic             norm_found;
    logic [IDX_W-1:0] sel_idx;
    logic             sel_valid;
    logic             lock_hit;
    logic [IDX_W-1:0] ptr_next;

    // First set request scanning from ptr upward with wrap.
    always_comb begin
        logic [IDX_W-1:0] k;
        norm_found = 1'b0;
        norm_idx   = '0;
        k          = '0;
        for (int unsigned i = 0; i < N; i++) begin
            k = IDX_W'((32'(ptr) + i) % N);
            if (!norm_found && requests[k]) begin
                norm_found = 1'b1;
                norm_idx   = k;
            end
        end
    end

`ifdef ROUND_ROBIN_ARBITER_N_LOCK_EN
    logic [IDX_W-1:0] owner;
    logic [7:0]       cnt;
    logic             tenure;

    // Continuation only while the previous cycle granted owner and budget remains.
    assign lock_hit  = tenure && requests[owner] && (cnt < 8'(MAX_HOLD));
    assign sel_idx   = lock_hit ? owner : norm_idx;
    assign sel_valid = lock_hit | norm_found;
`else
    assign lock_hit  = 1'b0;
    assign sel_idx   = norm_idx;
    assign sel_valid = norm_found;
`endif

    assign ptr_next = IDX_W'((32'(norm_idx) + 32'd1) % N);

    // Reset forces the combinational outputs low without waiting for a clock.
    assign grant_valid = !rst && sel_valid;
    assign grants      = grant_valid ? (N'(1'b1) << sel_idx) : '0;
    assign grant_idx   = grant_valid ? sel_idx : '0;
    assign locked      = !rst && lock_hit;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr <= '0;
        end else if (sel_valid && !lock_hit) begin
            ptr <= ptr_next;
        end
    end

`ifdef ROUND_ROBIN_ARBITER_N_LOCK_EN
    // Tenure tracking: a normal grant opens a tenure, an idle cycle closes it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            owner  <= '0;
            cnt    <= '0;
            tenure <= 1'b0;
        end else if (lock_hit) begin
            cnt <= cnt + 8'd1;
        end else if (norm_found) begin
            owner  <= norm_idx;
            cnt    <= 8'd1;
            tenure <= 1'b1;
        end else begin
            cnt    <= '0;
            tenure <= 1'b0;
        end
    end
`endif

endmodule

// File: tb/tb_round_robin_arbiter_n.sv
// Scoreboard bench for round_robin_arbiter_n: directed vectors push expectations,
// a negedge monitor pops and compares against the selected DUT instance.
module tb_round_robin_arbiter_n;

    typedef struct {
        int         sel;
        string      nm;
        logic [3:0] g;
        logic [1:0] idx;
        logic       v;
        logic       lk;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    logic       clk;
    logic       rst;
    logic [3:0] req4;
    logic [3:0] g4;
    logic       v4;
    logic [1:0] i4;
    logic       l4;
    logic [1:0] req2;
    logic [1:0] g2;
    logic       v2;
    logic [0:0] i2;
    logic       l2;

    // MAX_HOLD = 1 makes these instances behave as plain round-robin in either build.
    round_robin_arbiter_n #(.N(4), .MAX_HOLD(1)) dut4 (
        .clk(clk), .rst(rst), .requests(req4), .grants(g4),
        .grant_valid(v4), .grant_idx(i4), .locked(l4)
    );

    round_robin_arbiter_n #(.N(2), .MAX_HOLD(1)) dut2 (
        .clk(clk), .rst(rst), .requests(req2), .grants(g2),
        .grant_valid(v2), .grant_idx(i2), .locked(l2)
    );

`ifdef ROUND_ROBIN_ARBITER_N_LOCK_EN
    logic [3:0] reql;
    logic [3:0] gl;
    logic       vl;
    logic [1:0] il;
    logic       ll;

    round_robin_arbiter_n #(.N(4), .MAX_HOLD(3)) dutl (
        .clk(clk), .rst(rst), .requests(reql), .grants(gl),
        .grant_valid(vl), .grant_idx(il), .locked(ll)
    );
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step(input int sel, input logic r, input logic [3:0] rq,
                        input logic [3:0] eg, input logic [1:0] ei, input logic el,
                        input string nm);
        exp_t e;
        @(posedge clk);
        #1;
        rst  = r;
        req4 = '0;
        req2 = '0;
`ifdef ROUND_ROBIN_ARBITER_N_LOCK_EN
        reql = '0;
`endif
        case (sel)
            0: req4 = rq;
            1: req2 = rq[1:0];
`ifdef ROUND_ROBIN_ARBITER_N_LOCK_EN
            default: reql = rq;
`else
            default: ;
`endif
        endcase
        e.sel = sel;
        e.nm  = nm;
        e.g   = eg;
        e.idx = ei;
        e.v   = |eg;
        e.lk  = el;
        q.push_back(e);
    endtask

    // Monitor: compare the DUT output presented in the middle of each cycle.
    initial begin
        exp_t       e;
        logic [3:0] ag;
        logic [1:0] ai;
        logic       av;
        logic       al;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e  = q.pop_front();
                ag = '0;
                ai = '0;
                av = 1'b0;
                al = 1'b0;
                case (e.sel)
                    0: begin ag = g4; ai = i4; av = v4; al = l4; end
                    1: begin ag = {2'b00, g2}; ai = {1'b0, i2}; av = v2; al = l2; end
`ifdef ROUND_ROBIN_ARBITER_N_LOCK_EN
                    default: begin ag = gl; ai = il; av = vl; al = ll; end
`else
                    default: ;
`endif
                endcase
                n_checks++;
                if (ag !== e.g || ai !== e.idx || av !== e.v || al !== e.lk) begin
                    n_fail++;
                    $display("FAIL %s: got grants=%b idx=%0d valid=%b locked=%b, want grants=%b idx=%0d valid=%b locked=%b",
                             e.nm, ag, ai, av, al, e.g, e.idx, e.v, e.lk);
                end
            end
        end
    end

    initial begin
        rst  = 1'b1;
        req4 = '0;
        req2 = '0;
`ifdef ROUND_ROBIN_ARBITER_N_LOCK_EN
        reql = '0;
`endif
        // N=4: reset holds grants low even with requests pending.
        step(0, 1'b1, 4'b0000, 4'b0000, 2'd0, 1'b0, "n4_rst_idle");
        step(0, 1'b1, 4'b1111, 4'b0000, 2'd0, 1'b0, "n4_rst_req");
        // All requesting: strict rotation from ptr 0.
        step(0, 1'b0, 4'b1111, 4'b0001, 2'd0, 1'b0, "n4_all_0");
        step(0, 1'b0, 4'b1111, 4'b0010, 2'd1, 1'b0, "n4_all_1");
        step(0, 1'b0, 4'b1111, 4'b0100, 2'd2, 1'b0, "n4_all_2");
        step(0, 1'b0, 4'b1111, 4'b1000, 2'd3, 1'b0, "n4_all_3");
        step(0, 1'b0, 4'b1111, 4'b0001, 2'd0, 1'b0, "n4_all_4");
        step(0, 1'b0, 4'b1111, 4'b0010, 2'd1, 1'b0, "n4_all_5");
        step(0, 1'b0, 4'b1111, 4'b0100, 2'd2, 1'b0, "n4_all_6");
        step(0, 1'b0, 4'b1111, 4'b1000, 2'd3, 1'b0, "n4_all_7");
        // Pointer wrap 3 -> 0 -> 1.
        step(0, 1'b0, 4'b1000, 4'b1000, 2'd3, 1'b0, "n4_wrap_a");
        step(0, 1'b0, 4'b0001, 4'b0001, 2'd0, 1'b0, "n4_wrap_b");
        step(0, 1'b0, 4'b1001, 4'b1000, 2'd3, 1'b0, "n4_wrap_c");
        // Idle gap between single-requester grants.
        step(0, 1'b0, 4'b0010, 4'b0010, 2'd1, 1'b0, "n4_gap_a");
        step(0, 1'b0, 4'b0000, 4'b0000, 2'd0, 1'b0, "n4_gap_i0");
        step(0, 1'b0, 4'b0000, 4'b0000, 2'd0, 1'b0, "n4_gap_i1");
        step(0, 1'b0, 4'b0000, 4'b0000, 2'd0, 1'b0, "n4_gap_i2");
        step(0, 1'b0, 4'b0010, 4'b0010, 2'd1, 1'b0, "n4_gap_b");
        // Two requesters with ptr at 2 then 3.
        step(0, 1'b0, 4'b0110, 4'b0100, 2'd2, 1'b0, "n4_pair_a");
        step(0, 1'b0, 4'b0110, 4'b0010, 2'd1, 1'b0, "n4_pair_b");

        // N=2 reference sequence.
        step(1, 1'b1, 4'b0000, 4'b0000, 2'd0, 1'b0, "n2_rst");
        step(1, 1'b0, 4'b0001, 4'b0001, 2'd0, 1'b0, "n2_s0");
        step(1, 1'b0, 4'b0000, 4'b0000, 2'd0, 1'b0, "n2_s1");
        step(1, 1'b0, 4'b0010, 4'b0010, 2'd1, 1'b0, "n2_s2");
        step(1, 1'b0, 4'b0011, 4'b0001, 2'd0, 1'b0, "n2_s3");
        step(1, 1'b0, 4'b0011, 4'b0010, 2'd1, 1'b0, "n2_s4");
        step(1, 1'b0, 4'b0000, 4'b0000, 2'd0, 1'b0, "n2_s5");
        step(1, 1'b0, 4'b0011, 4'b0001, 2'd0, 1'b0, "n2_s6");
        step(1, 1'b0, 4'b0000, 4'b0000, 2'd0, 1'b0, "n2_s7");
        step(1, 1'b0, 4'b0011, 4'b0010, 2'd1, 1'b0, "n2_s8");
        step(1, 1'b0, 4'b0011, 4'b0001, 2'd0, 1'b0, "n2_s9");

`ifdef ROUND_ROBIN_ARBITER_N_LOCK_EN
        // Lock tenure with MAX_HOLD = 3.
        step(2, 1'b1, 4'b0000, 4'b0000, 2'd0, 1'b0, "lk_rst");
        step(2, 1'b0, 4'b0011, 4'b0001, 2'd0, 1'b0, "lk_t0");
        step(2, 1'b0, 4'b0011, 4'b0001, 2'd0, 1'b1, "lk_t1");
        step(2, 1'b0, 4'b0011, 4'b0001, 2'd0, 1'b1, "lk_t2");
        step(2, 1'b0, 4'b0011, 4'b0010, 2'd1, 1'b0, "lk_t3");
        step(2, 1'b0, 4'b0011, 4'b0010, 2'd1, 1'b1, "lk_t4");
        // Reset mid-tenure discards ownership.
        step(2, 1'b1, 4'b0000, 4'b0000, 2'd0, 1'b0, "lk_rst2");
        step(2, 1'b0, 4'b0101, 4'b0001, 2'd0, 1'b0, "lk_r0");
        step(2, 1'b1, 4'b0101, 4'b0000, 2'd0, 1'b0, "lk_rmid");
        step(2, 1'b0, 4'b0101, 4'b0001, 2'd0, 1'b0, "lk_r1");
        step(2, 1'b0, 4'b0101, 4'b0001, 2'd0, 1'b1, "lk_r2");
`endif

        repeat (3) @(posedge clk);
        if (q.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain: %0d expectations left unchecked, want 0", q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
